float_mul_stream: RTL and testbench

FLOAT_MUL_STREAM -- requirements
Module: float_mul_stream

---
 rtl/float_pkg.sv | 38 +++
 rtl/float_pipe_reg.sv | 30 +++
 rtl/float_mul_stream.sv | 171 +++++++++++++++++
 tb/tb_float_mul_stream.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared floating-point constants and helpers for the streaming multiplier.
package float_pkg;

   localparam int FLAG_INVALID   = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   function automatic int float_size(input int m, input int e);
      return 1 + e + m;
   endfunction

   function automatic int bias(input int e);
      return (1 << (e - 1)) - 1;
   endfunction

   function automatic int exp_inf(input int e);
      return (1 << e) - 1;
   endfunction

   // Field positions within {sign, exponent, mantissa}.
   function automatic int sign_pos(input int m, input int e);
      return m + e;
   endfunction

   function automatic int exp_lsb(input int m);
      return m;
   endfunction

   // Quiet NaN: positive sign, all-ones exponent, only the mantissa MSB set.
   function automatic logic [63:0] canon_nan(input int m, input int e);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < e; i++) r[m + i] = 1'b1;
      r[m - 1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/float_pipe_reg.sv
// Valid+data pipeline register; one cycle; holds contents while en is low.
module float_pipe_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             vld_i,
   input  logic [WIDTH-1:0] dat_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] dat_o
);

   logic             vld_q;
   logic [WIDTH-1:0] dat_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else if (en) begin
         vld_q <= vld_i;
         dat_q <= dat_i;
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;

endmodule

// File: rtl/float_mul_stream.sv
// Streaming IEEE-style multiplier; latency 2+EXTRA_STAGES cycles, one result per cycle.
// Backpressure: a single global enable stalls every stage while the output is held.
module float_mul_stream
   import float_pkg::*;
#(
   parameter int MANTISSA_SIZE      = 23,
   parameter int EXPONENT_SIZE      = 8,
   parameter int EXTRA_STAGES       = 2,
   parameter int ROUND_NEAREST_EVEN = 1,
   parameter int TAG_WIDTH          = 4,
   localparam int FLOAT_SIZE        = float_size(MANTISSA_SIZE, EXPONENT_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FLOAT_SIZE-1:0] facA,
   input  logic [FLOAT_SIZE-1:0] facB,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FLOAT_SIZE-1:0] prod,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [2:0]            out_flags
);

   localparam int M        = MANTISSA_SIZE;
   localparam int E        = EXPONENT_SIZE;
   localparam int PW       = 2 * (M + 1);
   localparam int EW       = E + 2;
   localparam int W        = FLOAT_SIZE + TAG_WIDTH + 3;
   localparam int SIGN_POS = sign_pos(M, E);
   localparam int EXP_LSB  = exp_lsb(M);
   localparam logic signed [EW-1:0] BIAS_S    = EW'(bias(E));
   localparam logic signed [EW-1:0] EXP_INF_S = EW'(exp_inf(E));
   localparam logic [63:0]           QNAN_W    = canon_nan(M, E);
   localparam logic [FLOAT_SIZE-1:0] QNAN      = QNAN_W[FLOAT_SIZE-1:0];

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // ---------------- stage 1: unpack, classify, multiply ----------------
   logic                 s1_vld_q, s1_sign_q, s1_inv_q, s1_inf_q, s1_zero_q;
   logic                 s1_sign_d, s1_inv_d, s1_inf_d, s1_zero_d;
   logic signed [EW-1:0] s1_exp_q, s1_exp_d;
   logic [PW-1:0]        s1_mant_q, s1_mant_d;
   logic [TAG_WIDTH-1:0] s1_tag_q;

   always_comb begin
      logic [E-1:0] ea, eb;
      logic [M-1:0] fa, fb;
      logic         nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      ea     = facA[EXP_LSB +: E];
      eb     = facB[EXP_LSB +: E];
      fa     = facA[M-1:0];
      fb     = facB[M-1:0];
      nan_a  = (&ea) && (|fa);
      nan_b  = (&eb) && (|fb);
      inf_a  = (&ea) && !(|fa);
      inf_b  = (&eb) && !(|fb);
      zero_a = !(|ea);
      zero_b = !(|eb);
      s1_sign_d = facA[SIGN_POS] ^ facB[SIGN_POS];
      s1_inv_d  = nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b);
      s1_inf_d  = inf_a || inf_b;
      s1_zero_d = zero_a || zero_b;
      s1_mant_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
      s1_exp_d  = EW'(ea) + EW'(eb) - BIAS_S;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q  <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_inv_q  <= 1'b0;
         s1_inf_q  <= 1'b0;
         s1_zero_q <= 1'b0;
         s1_exp_q  <= '0;
         s1_mant_q <= '0;
         s1_tag_q  <= '0;
      end else if (en) begin
         s1_vld_q  <= in_valid;
         s1_sign_q <= s1_sign_d;
         s1_inv_q  <= s1_inv_d;
         s1_inf_q  <= s1_inf_d;
         s1_zero_q <= s1_zero_d;
         s1_exp_q  <= s1_exp_d;
         s1_mant_q <= s1_mant_d;
         s1_tag_q  <= in_tag;
      end
   end

   // ---------------- stage 2: normalise, round, classify ----------------
   logic                  s2_vld_q;
   logic [W-1:0]          s2_dat_q, s2_dat_d;

   always_comb begin
      logic [M-1:0]          frac, frac_r;
      logic                  guard, sticky, round_up, carry;
      logic signed [EW-1:0]  exp_n, exp_r;
      logic [FLOAT_SIZE-1:0] res;
      logic [2:0]            flags;
      if (s1_mant_q[PW-1]) begin
         frac   = s1_mant_q[PW-2 -: M];
         guard  = s1_mant_q[M];
         sticky = |s1_mant_q[M-1:0];
         exp_n  = s1_exp_q + EW'(1);
      end else begin
         frac   = s1_mant_q[PW-3 -: M];
         guard  = s1_mant_q[M-1];
         sticky = |s1_mant_q[M-2:0];
         exp_n  = s1_exp_q;
      end
      round_up        = (ROUND_NEAREST_EVEN != 0) && guard && (sticky || frac[0]);
      // An all-ones fraction rounding up wraps to zero and bumps the exponent.
      {carry, frac_r} = {1'b0, frac} + (M + 1)'(round_up);
      exp_r           = exp_n + EW'(carry);
      flags = 3'b000;
      if (s1_inv_q) begin
         res                 = QNAN;
         flags[FLAG_INVALID] = 1'b1;
      end else if (s1_inf_q) begin
         res = {s1_sign_q, {E{1'b1}}, {M{1'b0}}};
      end else if (s1_zero_q) begin
         res = {s1_sign_q, {(FLOAT_SIZE-1){1'b0}}};
      end else if (exp_r >= EXP_INF_S) begin
         res                  = {s1_sign_q, {E{1'b1}}, {M{1'b0}}};
         flags[FLAG_OVERFLOW] = 1'b1;
      end else if (exp_r < EW'(1)) begin
         res                   = {s1_sign_q, {(FLOAT_SIZE-1){1'b0}}};
         flags[FLAG_UNDERFLOW] = 1'b1;
      end else begin
         res = {s1_sign_q, exp_r[E-1:0], frac_r};
      end
      s2_dat_d = {res, s1_tag_q, flags};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_vld_q <= 1'b0;
         s2_dat_q <= '0;
      end else if (en) begin
         s2_vld_q <= s1_vld_q;
         s2_dat_q <= s2_dat_d;
      end
   end

   // ---------------- optional output retiming ----------------
   logic [EXTRA_STAGES:0]        chain_vld;
   logic [EXTRA_STAGES:0][W-1:0] chain_dat;

   assign chain_vld[0] = s2_vld_q;
   assign chain_dat[0] = s2_dat_q;

   for (genvar g = 0; g < EXTRA_STAGES; g++) begin : g_extra
      float_pipe_reg #(.WIDTH(W)) u_reg (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .vld_i (chain_vld[g]),
         .dat_i (chain_dat[g]),
         .vld_o (chain_vld[g+1]),
         .dat_o (chain_dat[g+1])
      );
   end

   assign out_valid                  = chain_vld[EXTRA_STAGES];
   assign {prod, out_tag, out_flags} = chain_dat[EXTRA_STAGES];

endmodule

// File: tb/tb_float_mul_stream.sv
// Directed and randomised checks of float_mul_stream against a behavioural model.
module tb_float_mul_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, out_ready;
   logic [31:0] facA, facB;
   logic [3:0]  in_tag;
   logic        in_ready, out_valid;
   logic [31:0] prod;
   logic [3:0]  out_tag;
   logic [2:0]  out_flags;
   logic        in_ready_t, out_valid_t;
   logic [31:0] prod_t;
   logic [3:0]  out_tag_t;
   logic [2:0]  out_flags_t;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   float_mul_stream u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .facA(facA), .facB(facB), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .prod(prod), .out_tag(out_tag), .out_flags(out_flags)
   );

   float_mul_stream #(.ROUND_NEAREST_EVEN(0)) u_trunc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
      .facA(facA), .facB(facB), .in_tag(in_tag), .out_valid(out_valid_t),
      .out_ready(out_ready), .prod(prod_t), .out_tag(out_tag_t), .out_flags(out_flags_t)
   );

   task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", nm, obs, exp_v);
      end
   endtask

   // Returns {invalid, overflow, underflow, product}.
   function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rne);
      logic            sg;
      int              ea, eb, e, sh;
      logic [22:0]     fa, fb;
      longint unsigned p, q, rem, half;
      bit              nan_x, inf_x, zero_x;
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      fa = a[22:0];        fb = b[22:0];
      sg = a[31] ^ b[31];
      nan_x  = (ea == 255 && fa != 0) || (eb == 255 && fb != 0);
      inf_x  = (ea == 255) || (eb == 255);
      zero_x = (ea == 0) || (eb == 0);
      if (nan_x || (inf_x && zero_x)) return {3'b100, 32'h7FC00000};
      if (inf_x) return {3'b000, sg, 8'hFF, 23'd0};
      if (zero_x) return {3'b000, sg, 31'd0};
      p = 64'({1'b1, fa}) * 64'({1'b1, fb});
      if (p >= (64'd1 << 47)) begin sh = 24; e = ea + eb - 126; end
      else begin sh = 23; e = ea + eb - 127; end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rne && (rem > half || (rem == half && q[0]))) q = q + 1;
      if (q >= (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) return {3'b010, sg, 8'hFF, 23'd0};
      if (e < 1) return {3'b001, sg, 31'd0};
      return {3'b000, sg, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      int          sel;
      logic [7:0]  e;
      logic [22:0] f;
      sel = $urandom_range(0, 9);
      f   = 23'($urandom);
      if (sel == 0) e = 8'd0;
      else if (sel == 1) begin
         e = 8'hFF;
         if ($urandom_range(0, 1) == 0) f = '0;
      end else if (sel == 2) e = 8'($urandom_range(1, 254));
      else e = 8'($urandom_range(64, 190));
      return {1'($urandom), e, f};
   endfunction

   task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] exp_p, input logic [2:0] exp_f,
                        input logic [31:0] exp_pt);
      int n;
      @(negedge clk);
      facA = a; facB = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_latency"}, 64'(n), 64'(4));
      check({nm, "_valid"}, 64'(out_valid), 64'(1));
      check({nm, "_prod"}, 64'(prod), 64'(exp_p));
      check({nm, "_tag"}, 64'(out_tag), 64'(t));
      check({nm, "_flags"}, 64'(out_flags), 64'(exp_f));
      check({nm, "_trunc_valid"}, 64'(out_valid_t), 64'(1));
      check({nm, "_trunc_prod"}, 64'(prod_t), 64'(exp_pt));
      check({nm, "_trunc_tag"}, 64'(out_tag_t), 64'(t));
      check({nm, "_trunc_flags"}, 64'(out_flags_t), 64'(exp_f));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [38:0] expq[$];
      logic [38:0] held, exp_w;
      logic [34:0] r;
      bit          stall_prev;
      int          sent, got, cyc;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      facA = '0; facB = '0; in_tag = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_prod", 64'(prod), 64'(0));
      check("rst_tag", 64'(out_tag), 64'(0));
      check("rst_flags", 64'(out_flags), 64'(0));

      do_op("two_x_three", 32'h40000000, 32'h40400000, 4'd5, 32'h40C00000, 3'b000, 32'h40C00000);
      do_op("round_tie",   32'h3F800001, 32'h3FC00000, 4'd6, 32'h3FC00002, 3'b000, 32'h3FC00001);
      do_op("overflow",    32'h7F000000, 32'h7F000000, 4'd7, 32'h7F800000, 3'b010, 32'h7F800000);
      do_op("underflow",   32'h00800000, 32'h00800000, 4'd8, 32'h00000000, 3'b001, 32'h00000000);
      do_op("inf_x_zero",  32'h7F800000, 32'h80000000, 4'd9, 32'h7FC00000, 3'b100, 32'h7FC00000);
      do_op("ninf_x_two",  32'hFF800000, 32'h40000000, 4'd10, 32'hFF800000, 3'b000, 32'hFF800000);

      // Random stream with random backpressure, scoreboarded in order.
      sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
      while ((sent < 100 || expq.size() > 0) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (stall_prev) begin
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_data", 64'({prod, out_tag, out_flags}), 64'(held));
         end
         if (sent < 100 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            facA     = rand_op();
            facB     = rand_op();
            in_tag   = sent[3:0];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (in_valid && in_ready) begin
            r = ref_mul(facA, facB, 1'b1);
            expq.push_back({r[31:0], in_tag, r[34:32]});
            sent++;
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("stream_extra_result", 64'(1), 64'(0));
            end else begin
               exp_w = expq.pop_front();
               check("stream_result", 64'({prod, out_tag, out_flags}), 64'(exp_w));
            end
            got++;
         end
         stall_prev = out_valid && !out_ready;
         held       = {prod, out_tag, out_flags};
      end
      in_valid = 1'b0;
      check("stream_count", 64'(got), 64'(100));

      // Mid-stream reset with three operations in flight.
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b1; facA = 32'h40000000; facB = 32'h40000000; in_tag = 4'd3;
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      check("post_rst_out_valid", 64'(out_valid), 64'(0));
      repeat (8) begin
         @(negedge clk);
         check("post_rst_no_result", 64'(out_valid), 64'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
